alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one registered ALU (1-cycle output register, 4-bit function code) between N_REQ requesters.
- Accepts one operation per requester via valid/ready and picks the winner by round-robin.
- Sequences the ALU enable, waits for the ALU valid, then returns the result tagged with the requester id.
- Sits between client blocks (register file / UART command decoder) and the ALU instance; exactly one operation is in flight at a time.

Parameters:
- OPER_WIDTH, 8, operand width (matches ALU).
- OUT_WIDTH, 2*OPER_WIDTH, ALU result width.
- N_REQ, 4, number of requesters (2..8).
- ID_WIDTH, $clog2(N_REQ), requester id width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  async reset, active-low
- i_req_valid  in  N_REQ  per-requester op valid
- i_req_a  in  N_REQ*OPER_WIDTH  packed operand A; slice k belongs to requester k
- i_req_b  in  N_REQ*OPER_WIDTH  packed operand B
- i_req_fun  in  N_REQ*4  packed function codes
- o_req_ready  out  N_REQ  one-hot accept pulse
- o_alu_a  out  OPER_WIDTH  to ALU i_a
- o_alu_b  out  OPER_WIDTH  to ALU i_b
- o_alu_fun  out  4  to ALU i_fun
- o_alu_en  out  1  to ALU i_en
- i_alu_out  in  OUT_WIDTH  from ALU o_alu_out
- i_alu_valid  in  1  from ALU o_out_valid
- o_rsp_valid  out  1  response valid
- o_rsp_id  out  ID_WIDTH  requester that owns the response
- o_rsp_data  out  OUT_WIDTH  result
- o_rsp_err  out  1  error flag (see Optional Feature)
- i_rsp_ready  in  1  response consumer ready

Behaviour:
- Reset and clock: clock i_clk; reset i_rst, asynchronous, active-low.
- Reset values: all outputs 0; FSM IDLE; rr pointer = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any i_req_valid is set, grant the first valid requester searching from pointer+1 with modulo wrap.
  - o_req_ready[g] is asserted combinationally that cycle (one-hot, only in IDLE).
  - Latch a/b/fun/id; pointer <= g; go to ISSUE.
  - With no valid request, stay in IDLE with o_req_ready = 0.
- ISSUE:
  - o_alu_en = 1 for exactly one cycle; o_alu_a/b/fun driven from the latched values.
  - Go to WAIT.
- WAIT:
  - o_alu_en = 0; o_alu_a/b/fun stay held.
  - On i_alu_valid, capture i_alu_out into o_rsp_data and go to RESP.
- RESP:
  - o_rsp_valid = 1; o_rsp_id, o_rsp_data and o_rsp_err held stable.
  - On i_rsp_ready, go to IDLE.
  - o_rsp_valid must not drop without i_rsp_ready.
- Latency: accept at cycle 0, o_alu_en at cycle 1, ALU valid at cycle 2, o_rsp_valid at cycle 3. Best-case throughput is one op per 4 cycles (RESP→IDLE accept needs no bubble beyond the state itself).
- Fairness: a requester that was just granted is searched last; with all N_REQ requesting, grants rotate 0,1,2,…,N_REQ-1,0.
- i_req_* of non-granted requesters is ignored; those requesters must hold valid until ready, and the scheduler never drops a request.
- An i_alu_valid seen outside WAIT is ignored.
- Asserting i_rst mid-operation aborts the in-flight op: no response is produced and the requester is not re-served unless it re-asserts.
- Result width/meaning is exactly what the ALU returns; no arithmetic is done here, except in the optional feature.

Optional Feature:
- Macro: ALU_RR_SCHED_DIV0_EN.
- Defined: in IDLE, a granted op with fun == ALU_FUN_DIV and operand B == 0 bypasses ISSUE/WAIT.
  - Goes straight to RESP next cycle with o_rsp_data = all-ones and o_rsp_err = 1.
  - o_alu_en is never raised for it.
  - The rr pointer still advances.
- Undefined: DIV by 0 is issued to the ALU like any other op, and o_rsp_err is tied 0.

Decomposition:
- Shared package/header alu_pkg holds:
  - the 4-bit ALU function codes: ALU_FUN_ADD=0 … ALU_FUN_DIV=3 … ALU_FUN_SHL=14, same encoding as the ALU;
  - the FSM state encoding (2 bits);
  - the width of the function field.
- One sub-module is natural: rr_arbiter (N_REQ request vector + pointer → one-hot grant + encoded index), purely combinational, reused elsewhere.

Test Plan:
- Single request: req0 valid, a=8'd7, b=8'd5, fun=ADD → ready0 at cycle 0, o_alu_en at cycle 1 with a=7/b=5, o_rsp_valid at cycle 3 with id=0, data=16'd12.
- All four requesters valid continuously (MUL, a=k+1, b=3) → grants 0,1,2,3,0 in order; responses carry matching ids with data 3,6,9,12.
- Response back-pressure: i_rsp_ready held low 5 cycles in RESP → o_rsp_valid/id/data stable, no new ready pulses; the following accept happens only after the ready handshake.
- Reset asserted in WAIT → all outputs 0 immediately; after release, req2 alone is granted first; an ALU valid pulse arriving after reset produces no response.
- DIV0 with macro defined: req1 a=8'd9, b=0, fun=DIV → no o_alu_en; response at cycle 1, id=1, data=16'hFFFF, err=1. Without the macro: ALU issued, err=0.
- Stray i_alu_valid in IDLE with no requests → no o_rsp_valid; FSM stays in IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-code encoding (identical to the ALU),
// function-field width and the scheduler FSM state encoding.
package alu_pkg;

  localparam int unsigned ALU_FUN_W = 4;

  localparam logic [ALU_FUN_W-1:0] ALU_FUN_ADD   = 4'd0;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_SUB   = 4'd1;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_MUL   = 4'd2;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_DIV   = 4'd3;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_AND   = 4'd4;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_OR    = 4'd5;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_NAND  = 4'd6;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_NOR   = 4'd7;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_XOR   = 4'd8;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_XNOR  = 4'd9;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_CMPEQ = 4'd10;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_CMPGT = 4'd11;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_CMPLT = 4'd12;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_SHR   = 4'd13;
  localparam logic [ALU_FUN_W-1:0] ALU_FUN_SHL   = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past ptr and
// wraps, so the last winner (ptr) is considered last.
// Ports: req (request vector), ptr (last winner), grant_c (one-hot),
//        idx_c (encoded winner), any_c (some request present).
module rr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]    grant_c,
  output logic [ID_WIDTH-1:0] idx_c,
  output logic                any_c
);

  logic found;

  // First set request after ptr, modulo N_REQ
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!found && req[ID_WIDTH'((32'(ptr) + k) % N_REQ)]) begin
        grant_c[ID_WIDTH'((32'(ptr) + k) % N_REQ)] = 1'b1;
        idx_c = ID_WIDTH'((32'(ptr) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU between N_REQ requesters. One op in flight:
// accept (IDLE) -> enable ALU (ISSUE) -> wait for ALU valid (WAIT) ->
// hold tagged response until consumed (RESP).
// Ports: i_clk, i_rst (async, active-low); i_req_valid/a/b/fun (packed per
//        requester), o_req_ready (one-hot accept, combinational in IDLE);
//        o_alu_a/b/fun/en to the ALU, i_alu_out/i_alu_valid from it;
//        o_rsp_valid/id/data/err, i_rsp_ready toward the consumer.
// Build option: ALU_RR_SCHED_DIV0_EN answers DIV by zero locally with
//        all-ones data and o_rsp_err=1, without using the ALU.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned OPER_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 2 * OPER_WIDTH,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [N_REQ*OPER_WIDTH-1:0]   i_req_a,
  input  logic [N_REQ*OPER_WIDTH-1:0]   i_req_b,
  input  logic [N_REQ*ALU_FUN_W-1:0]    i_req_fun,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic [OPER_WIDTH-1:0]         o_alu_a,
  output logic [OPER_WIDTH-1:0]         o_alu_b,
  output logic [ALU_FUN_W-1:0]          o_alu_fun,
  output logic                          o_alu_en,
  input  logic [OUT_WIDTH-1:0]          i_alu_out,
  input  logic                          i_alu_valid,
  output logic                          o_rsp_valid,
  output logic [ID_WIDTH-1:0]           o_rsp_id,
  output logic [OUT_WIDTH-1:0]          o_rsp_data,
  output logic                          o_rsp_err,
  input  logic                          i_rsp_ready
);

  sched_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d, id_q, id_d, gnt_idx;
  logic [N_REQ-1:0]      gnt;
  logic                  gnt_any;
  logic [OPER_WIDTH-1:0] a_q, a_d, b_q, b_d, sel_a, sel_b;
  logic [ALU_FUN_W-1:0]  fun_q, fun_d, sel_fun;
  logic                  en_q, en_d, rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0]  data_q, data_d;
`ifdef ALU_RR_SCHED_DIV0_EN
  logic                  err_q, err_d;
`endif

  rr_arbiter #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req     (i_req_valid),
    .ptr     (ptr_q),
    .grant_c (gnt),
    .idx_c   (gnt_idx),
    .any_c   (gnt_any)
  );

  // Operand/function slice of the winning requester
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_fun = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_idx == ID_WIDTH'(k)) begin
        sel_a   = i_req_a[k*OPER_WIDTH +: OPER_WIDTH];
        sel_b   = i_req_b[k*OPER_WIDTH +: OPER_WIDTH];
        sel_fun = i_req_fun[k*ALU_FUN_W +: ALU_FUN_W];
      end
    end
  end

  // State and output registers; reset pointer to N_REQ-1 so requester 0 wins first
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ID_WIDTH'(N_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      en_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
`ifdef ALU_RR_SCHED_DIV0_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      en_q        <= en_d;
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
`ifdef ALU_RR_SCHED_DIV0_EN
      err_q       <= err_d;
`endif
    end
  end

  // Next state; en/rsp_valid are computed one cycle ahead so they line up with ISSUE/RESP
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    en_d        = 1'b0;
    rsp_valid_d = rsp_valid_q;
    data_d      = data_q;
    o_req_ready = '0;
`ifdef ALU_RR_SCHED_DIV0_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          o_req_ready = gnt;
          a_d         = sel_a;
          b_d         = sel_b;
          fun_d       = sel_fun;
          id_d        = gnt_idx;
          ptr_d       = gnt_idx;
`ifdef ALU_RR_SCHED_DIV0_EN
          if ((sel_fun == ALU_FUN_DIV) && (sel_b == '0)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            data_d      = '1;
            err_d       = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            en_d    = 1'b1;
            err_d   = 1'b0;
          end
`else
          state_d = ST_ISSUE;
          en_d    = 1'b1;
`endif
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_alu_valid) begin
          data_d      = i_alu_out;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_alu_a     = a_q;
  assign o_alu_b     = b_q;
  assign o_alu_fun   = fun_q;
  assign o_alu_en    = en_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_data  = data_q;
`ifdef ALU_RR_SCHED_DIV0_EN
  assign o_rsp_err   = err_q;
`else
  assign o_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: table of single ops plus hand-written
// sequences (rotation, back-pressure, reset in WAIT, stray ALU valid, DIV0).
// A 1-cycle registered ALU is modelled here; expected responses are queued
// at accept time and compared when the response handshake happens.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int unsigned OW = 8;
  localparam int unsigned RW = 16;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [NR-1:0]   i_req_valid;
  logic [NR*OW-1:0] i_req_a, i_req_b;
  logic [NR*4-1:0] i_req_fun;
  logic [NR-1:0]   o_req_ready;
  logic [OW-1:0]   o_alu_a, o_alu_b;
  logic [3:0]      o_alu_fun;
  logic            o_alu_en;
  logic [RW-1:0]   i_alu_out;
  logic            i_alu_valid;
  logic            o_rsp_valid;
  logic [IW-1:0]   o_rsp_id;
  logic [RW-1:0]   o_rsp_data;
  logic            o_rsp_err;
  logic            i_rsp_ready;

  alu_rr_scheduler #(.OPER_WIDTH(OW), .OUT_WIDTH(RW), .N_REQ(NR), .ID_WIDTH(IW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_fun(i_req_fun),
    .o_req_ready(o_req_ready),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_fun(o_alu_fun), .o_alu_en(o_alu_en),
    .i_alu_out(i_alu_out), .i_alu_valid(i_alu_valid),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [1:0] id; logic [15:0] data; logic err; } rsp_t;
  typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [3:0] fun; logic [15:0] exp; } vec_t;

  int n_vec = 0, n_err = 0;
  int cyc_n = 0, acc_cyc = -100, en_cyc = -100, rsp_cyc = -100;
  int n_acc = 0, n_en = 0, n_rsp = 0, ptr_m = NR - 1, last_grant = -1;
  bit hold_valid = 1'b0;
  logic alu_pend = 1'b0;
  logic [15:0] alu_res = '0;
  logic [7:0] exp_a, exp_b;
  logic [3:0] exp_fun;
  logic [1:0] last_id;
  logic [15:0] last_data;
  logic last_err;
  logic s_ready_any;
  rsp_t sbq[$];
  rsp_t rsp_log[$];
  int grant_log[$];
  logic [NR-1:0] nxt_valid = '0;
  logic [NR*OW-1:0] nxt_a = '0, nxt_b = '0;
  logic [NR*4-1:0] nxt_fun = '0;
  logic nxt_rsp_ready = 1'b1, nxt_stray = 1'b0;

  function automatic logic [15:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] f);
    logic [15:0] r;
    r = '0;
    case (f)
      ALU_FUN_ADD: r = 16'(a) + 16'(b);
      ALU_FUN_SUB: r = 16'(a) - 16'(b);
      ALU_FUN_MUL: r = 16'(a) * 16'(b);
      ALU_FUN_DIV: r = (b == 8'd0) ? 16'h0000 : 16'(a / b);
      default:     r = 16'h0000;
    endcase
    return r;
  endfunction

  function automatic int rr_pick(logic [NR-1:0] v, int p);
    for (int k = 1; k <= int'(NR); k++) begin
      if (v[(p + k) % int'(NR)]) return (p + k) % int'(NR);
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc_n);
    end
  endtask

  task automatic fail_now(string name, int got, int exp);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc_n);
  endtask

  // One clock: apply next inputs just after the edge, sample 1ns later
  task automatic tick();
    int g;
    rsp_t r;
    @(posedge i_clk);
    #1;
    i_req_valid = nxt_valid;
    i_req_a     = nxt_a;
    i_req_b     = nxt_b;
    i_req_fun   = nxt_fun;
    i_rsp_ready = nxt_rsp_ready;
    i_alu_valid = alu_pend | nxt_stray;
    i_alu_out   = alu_pend ? alu_res : 16'h5A5A;
    alu_pend    = 1'b0;
    #1;
    cyc_n++;
    s_ready_any = |o_req_ready;
    if (o_req_ready != '0) begin
      g = rr_pick(i_req_valid, ptr_m);
      if (g < 0) fail_now("spurious_ready", int'(o_req_ready), 0);
      else begin
        chk("grant", 32'(o_req_ready), 32'(4'b0001 << g));
        ptr_m = g; last_grant = g; acc_cyc = cyc_n; n_acc++;
        grant_log.push_back(g);
        exp_a   = i_req_a[g*OW +: OW];
        exp_b   = i_req_b[g*OW +: OW];
        exp_fun = i_req_fun[g*4 +: 4];
        r.id = 2'(g); r.data = alu_fn(exp_a, exp_b, exp_fun); r.err = 1'b0;
`ifdef ALU_RR_SCHED_DIV0_EN
        if (exp_fun == ALU_FUN_DIV && exp_b == 8'd0) begin r.data = 16'hFFFF; r.err = 1'b1; end
`endif
        sbq.push_back(r);
        if (!hold_valid) nxt_valid[g] = 1'b0;
      end
    end
    if (o_alu_en) begin
      n_en++; en_cyc = cyc_n;
      chk("alu_a", 32'(o_alu_a), 32'(exp_a));
      chk("alu_b", 32'(o_alu_b), 32'(exp_b));
      chk("alu_fun", 32'(o_alu_fun), 32'(exp_fun));
      alu_pend = 1'b1;
      alu_res  = alu_fn(o_alu_a, o_alu_b, o_alu_fun);
    end
    if (o_rsp_valid && i_rsp_ready) begin
      if (sbq.size() == 0) fail_now("unexpected_rsp", 1, 0);
      else begin
        r = sbq.pop_front();
        chk("rsp_id", 32'(o_rsp_id), 32'(r.id));
        chk("rsp_data", 32'(o_rsp_data), 32'(r.data));
        chk("rsp_err", 32'(o_rsp_err), 32'(r.err));
      end
      r.id = o_rsp_id; r.data = o_rsp_data; r.err = o_rsp_err;
      rsp_log.push_back(r);
      last_id = o_rsp_id; last_data = o_rsp_data; last_err = o_rsp_err;
      n_rsp++; rsp_cyc = cyc_n;
    end
  endtask

  task automatic wait_rsp(int target, int bound);
    int t = 0;
    while (n_rsp < target && t < bound) begin tick(); t++; end
    if (n_rsp < target) fail_now("rsp_timeout", n_rsp, target);
  endtask

  task automatic wait_acc(int target, int bound);
    int t = 0;
    while (n_acc < target && t < bound) begin tick(); t++; end
    if (n_acc < target) fail_now("acc_timeout", n_acc, target);
  endtask

  task automatic set_req(int id, logic [7:0] a, logic [7:0] b, logic [3:0] f);
    nxt_valid[id]      = 1'b1;
    nxt_a[id*OW +: OW] = a;
    nxt_b[id*OW +: OW] = b;
    nxt_fun[id*4 +: 4] = f;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_ready"}, 32'(o_req_ready), 32'd0);
    chk({tag, "_alu_a"}, 32'(o_alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(o_alu_b), 32'd0);
    chk({tag, "_alu_fun"}, 32'(o_alu_fun), 32'd0);
    chk({tag, "_alu_en"}, 32'(o_alu_en), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(o_rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, 32'(o_rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(o_rsp_err), 32'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    nxt_valid = '0; nxt_a = '0; nxt_b = '0; nxt_fun = '0; nxt_stray = 1'b0; nxt_rsp_ready = 1'b1;
    i_req_valid = '0; i_req_a = '0; i_req_b = '0; i_req_fun = '0;
    i_alu_valid = 1'b0; i_alu_out = '0; i_rsp_ready = 1'b1;
    alu_pend = 1'b0; hold_valid = 1'b0; ptr_m = NR - 1;
    sbq.delete();
    repeat (2) @(posedge i_clk);
    #3 i_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int exp_g[5];
    logic [15:0] exp_d[5];
    int r0, e0, a0;
    vecs[0] = '{id: 0, a: 8'd7,   b: 8'd5,   fun: ALU_FUN_ADD, exp: 16'd12};
    vecs[1] = '{id: 1, a: 8'd10,  b: 8'd3,   fun: ALU_FUN_SUB, exp: 16'd7};
    vecs[2] = '{id: 2, a: 8'd6,   b: 8'd7,   fun: ALU_FUN_MUL, exp: 16'd42};
    vecs[3] = '{id: 3, a: 8'd100, b: 8'd7,   fun: ALU_FUN_DIV, exp: 16'd14};
    vecs[4] = '{id: 0, a: 8'd255, b: 8'd255, fun: ALU_FUN_MUL, exp: 16'hFE01};
    vecs[5] = '{id: 1, a: 8'd3,   b: 8'd5,   fun: ALU_FUN_SUB, exp: 16'hFFFE};
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd3};

    // Reset values
    i_rst = 1'b0;
    i_req_valid = '0; i_req_a = '0; i_req_b = '0; i_req_fun = '0;
    i_alu_valid = 1'b0; i_alu_out = '0; i_rsp_ready = 1'b1;
    #2;
    check_zero("reset");
    do_reset();

    // Table of single operations: grant, latency and result
    foreach (vecs[i]) begin
      r0 = n_rsp;
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].fun);
      wait_rsp(r0 + 1, 20);
      chk("vec_grant", 32'(last_grant), 32'(vecs[i].id));
      chk("vec_en_lat", 32'(en_cyc - acc_cyc), 32'd1);
      chk("vec_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd3);
      chk("vec_id", 32'(last_id), 32'(vecs[i].id));
      chk("vec_data", 32'(last_data), 32'(vecs[i].exp));
      tick();
    end

    // All requesters continuously valid: rotation 0,1,2,3,0 after reset
    do_reset();
    grant_log.delete(); rsp_log.delete();
    a0 = n_acc; r0 = n_rsp;
    hold_valid = 1'b1;
    for (int k = 0; k < int'(NR); k++) set_req(k, 8'(k + 1), 8'd3, ALU_FUN_MUL);
    wait_acc(a0 + 5, 40);
    hold_valid = 1'b0;
    nxt_valid = '0;
    wait_rsp(r0 + 5, 40);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) chk("rot_grant", 32'(grant_log[i]), 32'(exp_g[i]));
      if (i < rsp_log.size()) begin
        chk("rot_id", 32'(rsp_log[i].id), 32'(exp_g[i]));
        chk("rot_data", 32'(rsp_log[i].data), 32'(exp_d[i]));
      end
    end
    if (i_clk === 1'bx) fail_now("clock_dead", 0, 1);

    // Response back-pressure: hold 5 cycles in RESP, competing request waits
    tick();
    nxt_rsp_ready = 1'b0;
    set_req(2, 8'd4, 8'd4, ALU_FUN_ADD);
    begin
      int t = 0;
      while (!o_rsp_valid && t < 10) begin tick(); t++; end
      if (!o_rsp_valid) fail_now("bp_rsp_timeout", 0, 1);
    end
    set_req(3, 8'd2, 8'd9, ALU_FUN_ADD);
    a0 = n_acc;
    repeat (5) begin
      tick();
      chk("bp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_id", 32'(o_rsp_id), 32'd2);
      chk("bp_data", 32'(o_rsp_data), 32'd8);
      chk("bp_no_ready", 32'(s_ready_any), 32'd0);
    end
    chk("bp_no_accept", 32'(n_acc), 32'(a0));
    nxt_rsp_ready = 1'b1;
    r0 = n_rsp;
    tick();
    chk("bp_handshake", 32'(n_rsp), 32'(r0 + 1));
    wait_acc(a0 + 1, 5);
    chk("bp_acc_after_hs", 32'(acc_cyc - rsp_cyc), 32'd1);
    chk("bp_grant3", 32'(last_grant), 32'd3);
    wait_rsp(r0 + 2, 20);
    chk("bp_data3", 32'(last_data), 32'd11);
    tick();

    // Reset asserted while waiting for the ALU
    e0 = n_en;
    set_req(1, 8'd20, 8'd4, ALU_FUN_SUB);
    begin
      int t = 0;
      while (n_en == e0 && t < 10) begin tick(); t++; end
      if (n_en == e0) fail_now("rst_en_timeout", n_en, e0 + 1);
    end
    tick();
    chk("pre_rst_alu_a", 32'(o_alu_a), 32'd20);
    i_rst = 1'b0;
    #1;
    check_zero("rst_wait");
    do_reset();
    r0 = n_rsp; a0 = n_acc;
    nxt_stray = 1'b1;
    tick();
    nxt_stray = 1'b0;
    repeat (3) begin
      tick();
      chk("stray_no_rsp", 32'(o_rsp_valid), 32'd0);
    end
    chk("stray_rsp_count", 32'(n_rsp), 32'(r0));
    chk("no_reserve_req1", 32'(n_acc), 32'(a0));
    set_req(2, 8'd5, 8'd6, ALU_FUN_MUL);
    tick();
    chk("post_rst_acc_now", 32'(acc_cyc), 32'(cyc_n));
    chk("post_rst_grant2", 32'(last_grant), 32'd2);
    wait_rsp(r0 + 1, 20);
    chk("post_rst_data", 32'(last_data), 32'd30);
    tick();

    // Divide by zero
    e0 = n_en; r0 = n_rsp;
    set_req(1, 8'd9, 8'd0, ALU_FUN_DIV);
    wait_rsp(r0 + 1, 20);
    chk("div0_id", 32'(last_id), 32'd1);
`ifdef ALU_RR_SCHED_DIV0_EN
    chk("div0_no_en", 32'(n_en), 32'(e0));
    chk("div0_lat", 32'(rsp_cyc - acc_cyc), 32'd1);
    chk("div0_data", 32'(last_data), 32'hFFFF);
    chk("div0_err", 32'(last_err), 32'd1);
`else
    chk("div0_en", 32'(n_en), 32'(e0 + 1));
    chk("div0_lat", 32'(rsp_cyc - acc_cyc), 32'd3);
    chk("div0_data", 32'(last_data), 32'd0);
    chk("div0_err", 32'(last_err), 32'd0);
`endif
    repeat (2) tick();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
